// File: rtl/lifo_pop_streamer.sv
// Read-side master for the 8-bit LIFO: pops a programmed number of words
// and streams them out through a 2-entry skid buffer (valid/ready).
module lifo_pop_streamer #(
  parameter int DW    = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             lifo_pop,
  output logic             lifo_r_en,
  input  logic [DW-1:0]    lifo_out,
  input  logic             lifo_empty,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             underrun_q, underrun_n;
  logic             inflight;
  logic [DW-1:0]    skid0, skid1;
  logic [1:0]       occ;
  logic [1:0]       need;
  logic             xfer;
  logic             credit;
  logic             pop;

  assign m_valid = (occ != 2'd0);
  assign m_data  = skid0;
  assign xfer    = m_valid & m_ready;

  // Slots committed next cycle: held words plus the word in flight,
  // minus the one leaving now.
  assign need    = occ + {1'b0, inflight} - {1'b0, xfer};
  assign credit  = (need < 2'd2);

  assign pop = (state == S_POP) & (remaining != '0)
             & ~lifo_empty & credit;

  assign lifo_pop  = pop;
  assign lifo_r_en = pop;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign underrun  = underrun_q;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    underrun_n  = underrun_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          underrun_n = 1'b0;
          if (count != '0) begin
            remaining_n = count;
            state_n     = S_POP;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_POP: begin
        if (pop) begin
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_n = S_FLUSH;
        end else if (lifo_empty && !inflight) begin
          underrun_n  = 1'b1;
          remaining_n = '0;
          state_n     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!inflight && occ == 2'd0) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      underrun_q <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      underrun_q <= underrun_n;
      inflight   <= pop;
    end
  end

  // Capture of the in-flight word and head transfer may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      unique case ({inflight, xfer})
        2'b10: begin
          if (occ == 2'd0) skid0 <= lifo_out;
          else             skid1 <= lifo_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            skid0 <= skid1;
            skid1 <= lifo_out;
          end else begin
            skid0 <= lifo_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
